// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer game controller.
//   rt_state_t : sequencer states
//   MS_W       : width of every millisecond quantity (0..9999 fits in 14 bits)
//   LFSR_SEED  : value loaded into the hold-off LFSR on reset
//   lfsr_step  : one shift of the 16-bit Fibonacci LFSR, taps 16,14,13,11
package reaction_pkg;

  typedef enum logic [2:0] {IDLE, ARM, GO, DONE, FOUL} rt_state_t;

  localparam int          MS_W      = 14;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to randomise the GO hold-off.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset, reloads LFSR_SEED
//   q   : current LFSR state, advances every clock
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= LFSR_SEED;
    else     q <= lfsr_step(q);
  end

endmodule

// File: rtl/reaction_controller.sv
// Top-level sequencer for the reaction-timer game: waits for start, holds off a
// pseudo-random delay, lights GO and runs the stopwatch, latches the reaction
// time, flags false starts and timeouts, and tracks the best score.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   btn_start    : single-cycle pulse, begin a round
//   btn_react    : single-cycle pulse, player reaction
//   elapsed_ms   : stopwatch elapsed time, 0..MAX_MS
//   start_watch  : run enable for the stopwatch
//   watch_rst    : one-cycle clear pulse for the stopwatch
//   led_go       : GO lamp
//   foul         : false-start indicator
//   timeout      : no press before MAX_MS
//   result_valid : result_ms is displayable
//   result_ms    : latched reaction time
//   best_ms      : lowest valid result since reset
module reaction_controller
  import reaction_pkg::*;
#(
  parameter int CLKS_PER_MS  = 100_000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_MS       = 9999,
  parameter int SHOW_MS      = 3000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_start,
  input  logic            btn_react,
  input  logic [MS_W-1:0] elapsed_ms,
  output logic            start_watch,
  output logic            watch_rst,
  output logic            led_go,
  output logic            foul,
  output logic            timeout,
  output logic            result_valid,
  output logic [MS_W-1:0] result_ms,
  output logic [MS_W-1:0] best_ms
);

  localparam int              TW        = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(CLKS_PER_MS - 1);
  localparam logic [MS_W-1:0] MS_MAX    = MS_W'(MAX_MS);
  localparam logic [MS_W-1:0] MIN_DLY   = MS_W'(MIN_DELAY_MS);
  localparam logic [MS_W-1:0] SHOW_LAST = MS_W'(SHOW_MS - 1);

  rt_state_t       state, state_next;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [15:0]     lfsr_q;
  logic            lfsr_unused;
  logic [MS_W-1:0] delay_cnt, delay_cnt_d;
  logic [MS_W-1:0] show_cnt, show_cnt_d;
  logic            start_watch_d, watch_rst_d, led_go_d, foul_d, timeout_d, result_valid_d;
  logic [MS_W-1:0] result_ms_d, best_ms_d;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the low 11 bits feed the hold-off; the rest just keep the sequence long.
  assign lfsr_unused = ^lfsr_q[15:11];

  assign tick = (tick_cnt == TICK_LAST);

  // ms tick divider, restarted whenever the state changes so every state
  // sees a full millisecond before its first tick
  always_ff @(posedge clk) begin
    if (rst)                                tick_cnt <= '0;
    else if (state_next != state || tick)   tick_cnt <= '0;
    else                                    tick_cnt <= tick_cnt + TW'(1);
  end

  always_comb begin
    state_next     = state;
    delay_cnt_d    = delay_cnt;
    show_cnt_d     = show_cnt;
    start_watch_d  = start_watch;
    watch_rst_d    = 1'b0;
    led_go_d       = led_go;
    foul_d         = foul;
    timeout_d      = timeout;
    result_valid_d = result_valid;
    result_ms_d    = result_ms;
    best_ms_d      = best_ms;
    case (state)
      IDLE, DONE, FOUL: begin
        if (btn_start) begin
          delay_cnt_d    = MIN_DLY + MS_W'(lfsr_q[10:0]);
          watch_rst_d    = 1'b1;
          start_watch_d  = 1'b0;
          led_go_d       = 1'b0;
          result_valid_d = 1'b0;
          foul_d         = 1'b0;
          timeout_d      = 1'b0;
          state_next     = ARM;
        end else if (state != IDLE && tick) begin
          // displays stay latched after the auto-return
          if (show_cnt == SHOW_LAST) state_next = IDLE;
          else                       show_cnt_d = show_cnt + MS_W'(1);
        end
      end
      ARM: begin
        if (btn_react) begin
          foul_d        = 1'b1;
          start_watch_d = 1'b0;
          led_go_d      = 1'b0;
          show_cnt_d    = '0;
          state_next    = FOUL;
        end else if (tick) begin
          if (delay_cnt == '0) begin
            led_go_d      = 1'b1;
            start_watch_d = 1'b1;
            state_next    = GO;
          end else begin
            delay_cnt_d = delay_cnt - MS_W'(1);
          end
        end
      end
      GO: begin
        if (btn_react) begin
          result_ms_d    = elapsed_ms;
          result_valid_d = 1'b1;
          start_watch_d  = 1'b0;
          led_go_d       = 1'b0;
          show_cnt_d     = '0;
          if (elapsed_ms < best_ms) best_ms_d = elapsed_ms;
          state_next     = DONE;
        end else if (elapsed_ms == MS_MAX) begin
          result_ms_d    = MS_MAX;
          timeout_d      = 1'b1;
          result_valid_d = 1'b1;
          start_watch_d  = 1'b0;
          led_go_d       = 1'b0;
          show_cnt_d     = '0;
          state_next     = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      delay_cnt    <= '0;
      show_cnt     <= '0;
      start_watch  <= 1'b0;
      watch_rst    <= 1'b0;
      led_go       <= 1'b0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
      result_valid <= 1'b0;
      result_ms    <= '0;
      best_ms      <= MS_MAX;
    end else begin
      state        <= state_next;
      delay_cnt    <= delay_cnt_d;
      show_cnt     <= show_cnt_d;
      start_watch  <= start_watch_d;
      watch_rst    <= watch_rst_d;
      led_go       <= led_go_d;
      foul         <= foul_d;
      timeout      <= timeout_d;
      result_valid <= result_valid_d;
      result_ms    <= result_ms_d;
      best_ms      <= best_ms_d;
    end
  end

endmodule

// File: tb/tb_reaction_controller.sv
module tb_reaction_controller;
  import reaction_pkg::*;

  localparam int CPM  = 4;
  localparam int MIND = 10;
  localparam int SHOW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_react = 1'b0;
  logic [13:0] elapsed_ms = '0;
  logic        start_watch, watch_rst, led_go, foul, timeout, result_valid;
  logic [13:0] result_ms, best_ms;

  int n_cmp = 0;
  int n_bad = 0;

  reaction_controller #(
    .CLKS_PER_MS (CPM),
    .MIN_DELAY_MS(MIND),
    .MAX_MS      (9999),
    .SHOW_MS     (SHOW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_react   (btn_react),
    .elapsed_ms  (elapsed_ms),
    .start_watch (start_watch),
    .watch_rst   (watch_rst),
    .led_go      (led_go),
    .foul        (foul),
    .timeout     (timeout),
    .result_valid(result_valid),
    .result_ms   (result_ms),
    .best_ms     (best_ms)
  );

  always #5 clk = ~clk;

  // reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting toward the MSB
  logic [15:0] lfsr_m;
  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[16-1] ^ lfsr_m[14-1] ^ lfsr_m[13-1] ^ lfsr_m[11-1]};
  end

  typedef struct {
    string       nm;
    logic [13:0] res;
    logic        rv;
    logic        to;
    logic        fl;
    logic        sw;
    logic        go;
    logic [13:0] best;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        press;
    logic [13:0] el;
    logic [13:0] res;
    logic        to;
    logic [13:0] best;
  } round_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic sb_pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      e = sb.pop_front();
      chk({e.nm, ".result_ms"},    32'(result_ms),    32'(e.res));
      chk({e.nm, ".result_valid"}, 32'(result_valid), 32'(e.rv));
      chk({e.nm, ".timeout"},      32'(timeout),      32'(e.to));
      chk({e.nm, ".foul"},         32'(foul),         32'(e.fl));
      chk({e.nm, ".start_watch"},  32'(start_watch),  32'(e.sw));
      chk({e.nm, ".led_go"},       32'(led_go),       32'(e.go));
      chk({e.nm, ".best_ms"},      32'(best_ms),      32'(e.best));
    end
  endtask

  // Pulses btn_start and checks the clears; returns the expected cycles to GO
  // counted from the start edge, derived from the reference LFSR.
  task automatic start_round(output int exp_go);
    int d;
    d = MIND + int'(lfsr_m[10:0]);
    exp_go = CPM * (d + 1);
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    chk("start.watch_rst", 32'(watch_rst), 32'd1);
    chk("start.rv_clr",    32'(result_valid), 32'd0);
    chk("start.foul_clr",  32'(foul), 32'd0);
    chk("start.to_clr",    32'(timeout), 32'd0);
    chk("start.state",     32'(dut.state), 32'(ARM));
    step();
    chk("start.watch_rst_off", 32'(watch_rst), 32'd0);
  endtask

  task automatic reach_go();
    int exp_go;
    int n;
    start_round(exp_go);
    n = 1;
    while (led_go !== 1'b1 && n < 9000) begin
      step();
      n++;
    end
    chk("go.latency",     32'(n), 32'(exp_go));
    chk("go.start_watch", 32'(start_watch), 32'd1);
  endtask

  task automatic press(input logic do_press, input logic [13:0] el, input exp_t e);
    elapsed_ms = el;
    btn_react  = do_press;
    sb.push_back(e);
    step();
    btn_react  = 1'b0;
    elapsed_ms = '0;
    sb_pop_check();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    round_t rounds[6];
    exp_t   e;
    int     exp_go;
    logic   seen_go;

    rounds[0] = '{press: 1'b0, el: 14'd9999, res: 14'd9999, to: 1'b1, best: 14'd245};
    rounds[1] = '{press: 1'b1, el: 14'd9999, res: 14'd9999, to: 1'b0, best: 14'd245};
    rounds[2] = '{press: 1'b1, el: 14'd300,  res: 14'd300,  to: 1'b0, best: 14'd245};
    rounds[3] = '{press: 1'b1, el: 14'd200,  res: 14'd200,  to: 1'b0, best: 14'd200};
    rounds[4] = '{press: 1'b1, el: 14'd400,  res: 14'd400,  to: 1'b0, best: 14'd200};
    rounds[5] = '{press: 1'b1, el: 14'd0,    res: 14'd0,    to: 1'b0, best: 14'd0};

    // reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    e = '{nm: "reset", res: 14'd0, rv: 1'b0, to: 1'b0, fl: 1'b0, sw: 1'b0, go: 1'b0, best: 14'd9999};
    sb.push_back(e);
    sb_pop_check();
    chk("reset.watch_rst", 32'(watch_rst), 32'd0);
    chk("reset.state",     32'(dut.state), 32'(IDLE));

    // react in IDLE is ignored
    e.nm = "idle_react";
    press(1'b1, 14'd77, e);
    chk("idle_react.state", 32'(dut.state), 32'(IDLE));

    // first valid round, with a start press during GO that must be ignored
    reach_go();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    chk("go_start_ign.state",     32'(dut.state), 32'(GO));
    chk("go_start_ign.watch_rst", 32'(watch_rst), 32'd0);
    chk("go_start_ign.led_go",    32'(led_go), 32'd1);
    e = '{nm: "r245", res: 14'd245, rv: 1'b1, to: 1'b0, fl: 1'b0, sw: 1'b0, go: 1'b0, best: 14'd245};
    press(1'b1, 14'd245, e);
    chk("r245.state", 32'(dut.state), 32'(DONE));
    for (int i = 0; i < CPM * SHOW; i++) step();
    chk("r245.auto_idle", 32'(dut.state), 32'(IDLE));
    chk("r245.held_rv",   32'(result_valid), 32'd1);

    // false start: react three ticks after start
    start_round(exp_go);
    seen_go = 1'b0;
    for (int i = 2; i < 3 * CPM; i++) begin
      step();
      seen_go = seen_go | led_go;
    end
    e = '{nm: "foul", res: 14'd245, rv: 1'b0, to: 1'b0, fl: 1'b1, sw: 1'b0, go: 1'b0, best: 14'd245};
    press(1'b1, 14'd0, e);
    chk("foul.led_go_never", 32'(seen_go), 32'd0);
    chk("foul.state",        32'(dut.state), 32'(FOUL));
    for (int i = 0; i < CPM * SHOW - 1; i++) step();
    chk("foul.hold_last", 32'(dut.state), 32'(FOUL));
    step();
    chk("foul.auto_idle", 32'(dut.state), 32'(IDLE));
    chk("foul.held",      32'(foul), 32'd1);

    // table rounds: timeout, press at timeout, best-score tracking, 0 ms press;
    // each new round starts straight from DONE
    for (int r = 0; r < 6; r++) begin
      reach_go();
      e = '{nm: $sformatf("round%0d", r), res: rounds[r].res, rv: 1'b1, to: rounds[r].to,
            fl: 1'b0, sw: 1'b0, go: 1'b0, best: rounds[r].best};
      press(rounds[r].press, rounds[r].el, e);
    end

    // reset during GO
    reach_go();
    rst = 1'b1;
    step();
    rst = 1'b0;
    e = '{nm: "rst_in_go", res: 14'd0, rv: 1'b0, to: 1'b0, fl: 1'b0, sw: 1'b0, go: 1'b0, best: 14'd9999};
    sb.push_back(e);
    sb_pop_check();
    chk("rst_in_go.state", 32'(dut.state), 32'(IDLE));

    // LFSR reseeded: hold-off after reset follows the reference sequence again
    reach_go();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
